// File: rtl/warmboot_ctrl_if.sv
// Signal bundle between the warm-boot controller, the fabric switch matrix
// and the top-level configuration controller.
interface warmboot_ctrl_if #(
  parameter int SLOT_W = 4
);
  logic              BOOT;
  logic [SLOT_W-1:0] SLOT;
  logic              RESET;
  logic              RESET_top;
  logic              CONFIGURED_top;
  logic              BOOT_top;
  logic [SLOT_W-1:0] SLOT_top;
  logic              BUSY;
  logic [1:0]        ERR;

  modport master (
    output BOOT, SLOT, RESET_top, CONFIGURED_top,
    input  RESET, BOOT_top, SLOT_top, BUSY, ERR
  );

  modport slave (
    input  BOOT, SLOT, RESET_top, CONFIGURED_top,
    output RESET, BOOT_top, SLOT_top, BUSY, ERR
  );
endinterface

// File: rtl/warmboot_ctrl.sv
// Warm-boot controller: synchronises the top-level status lines, filters the
// fabric boot request, issues a fixed-width boot pulse and supervises reconfiguration.
module warmboot_ctrl #(
  parameter int SLOT_W         = 4,
  parameter int MAX_SLOT       = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int PULSE_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input logic            UserCLK,
  input logic            resetn,
  warmboot_ctrl_if.slave bus
);

  localparam int HOLD_M  = (HOLD_CYCLES > 2) ? HOLD_CYCLES : 2;
  localparam int PULSE_M = (PULSE_CYCLES > 2) ? PULSE_CYCLES : 2;
  localparam int TO_M    = (TIMEOUT_CYCLES > 2) ? TIMEOUT_CYCLES : 2;
  localparam int CNT_MAX = (HOLD_M > PULSE_M) ? HOLD_M : PULSE_M;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int TCNT_W  = $clog2(TO_M) + 1;

  localparam logic [CNT_W-1:0]  HOLD_C  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  PULSE_C = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_ONE = TCNT_W'(1);
  localparam logic [SLOT_W:0]   MAX_C   = (SLOT_W + 1)'(MAX_SLOT);

  localparam logic [2:0] S_WAIT_CFG    = 3'd0;
  localparam logic [2:0] S_IDLE        = 3'd1;
  localparam logic [2:0] S_FILTER      = 3'd2;
  localparam logic [2:0] S_PULSE       = 3'd3;
  localparam logic [2:0] S_WAIT_RECONF = 3'd4;
  localparam logic [2:0] S_WAIT_REL    = 3'd5;

  logic [SYNC_STAGES-1:0] rst_sync, cfg_sync;
  logic                   cfg_s;
  logic [2:0]             state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [TCNT_W-1:0]      tcnt, tcnt_n;
  logic [SLOT_W-1:0]      slot_q, slot_q_n;
  logic [1:0]             err, err_n;
  logic                   boot_top, boot_top_n;
  logic [SLOT_W-1:0]      slot_top, slot_top_n;
  logic                   busy, busy_n;
  logic                   slot_bad;

  assign cfg_s    = cfg_sync[SYNC_STAGES-1];
  assign slot_bad = {1'b0, slot_q} > MAX_C;

  // The filter exit conditions are tested before the hold count, so a
  // configuration drop on the completing cycle suppresses both pulse and error.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tcnt_n     = tcnt;
    slot_q_n   = slot_q;
    err_n      = err;
    boot_top_n = 1'b0;
    slot_top_n = '0;
    case (state)
      S_WAIT_CFG: begin
        if (cfg_s) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (!cfg_s) begin
          state_n = S_WAIT_CFG;
        end else if (bus.BOOT) begin
          state_n  = S_FILTER;
          slot_q_n = bus.SLOT;
          cnt_n    = CNT_ONE;
        end
      end
      S_FILTER: begin
        if (!bus.BOOT || (bus.SLOT != slot_q) || !cfg_s) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt < HOLD_C) begin
          cnt_n = cnt + CNT_ONE;
        end else if (slot_bad) begin
          err_n[0] = 1'b1;
          state_n  = S_WAIT_REL;
          cnt_n    = '0;
        end else begin
          state_n = S_PULSE;
          cnt_n   = '0;
        end
      end
      S_PULSE: begin
        if (cnt == PULSE_C) begin
          state_n = S_WAIT_RECONF;
          cnt_n   = '0;
          tcnt_n  = '0;
        end else begin
          boot_top_n = 1'b1;
          slot_top_n = slot_q;
          cnt_n      = cnt + CNT_ONE;
        end
      end
      S_WAIT_RECONF: begin
        if (!cfg_s) begin
          state_n = S_WAIT_CFG;
        end else if (tcnt == TO_LAST) begin
          err_n[1] = 1'b1;
          state_n  = S_WAIT_REL;
        end else begin
          tcnt_n = tcnt + TCNT_ONE;
        end
      end
      S_WAIT_REL: begin
        if (!bus.BOOT) state_n = cfg_s ? S_IDLE : S_WAIT_CFG;
      end
      default: state_n = S_WAIT_CFG;
    endcase
  end

  assign busy_n = (state_n == S_FILTER) || (state_n == S_PULSE) ||
                  (state_n == S_WAIT_RECONF);

  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      rst_sync <= '0;
      cfg_sync <= '0;
      state    <= S_WAIT_CFG;
      cnt      <= '0;
      tcnt     <= '0;
      slot_q   <= '0;
      err      <= '0;
      boot_top <= 1'b0;
      slot_top <= '0;
      busy     <= 1'b0;
    end else begin
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], bus.RESET_top};
      cfg_sync <= {cfg_sync[SYNC_STAGES-2:0], bus.CONFIGURED_top};
      state    <= state_n;
      cnt      <= cnt_n;
      tcnt     <= tcnt_n;
      slot_q   <= slot_q_n;
      err      <= err_n;
      boot_top <= boot_top_n;
      slot_top <= slot_top_n;
      busy     <= busy_n;
    end
  end

  assign bus.RESET    = rst_sync[SYNC_STAGES-1];
  assign bus.BOOT_top = boot_top;
  assign bus.SLOT_top = slot_top;
  assign bus.BUSY     = busy;
  assign bus.ERR      = err;

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Directed-vector bench for warmboot_ctrl with default parameters; each
// scenario task checks its own hand-computed expectations.
module tb_warmboot_ctrl;

  logic clk = 1'b0;
  logic resetn;
  int   vectors = 0;
  int   miscompares = 0;

  warmboot_ctrl_if #(.SLOT_W(4)) bus ();

  warmboot_ctrl #(
    .SLOT_W(4), .MAX_SLOT(3), .HOLD_CYCLES(4), .PULSE_CYCLES(8),
    .TIMEOUT_CYCLES(1024), .SYNC_STAGES(2)
  ) dut (
    .UserCLK(clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drops and restores CONFIGURED_top so the FSM ends up back in IDLE.
  task automatic complete_reconf();
    bus.CONFIGURED_top = 1'b0;
    tick(3);
    bus.CONFIGURED_top = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.BOOT = 1'b0;
    bus.SLOT = 4'd0;
    bus.RESET_top = 1'b1;
    bus.CONFIGURED_top = 1'b1;
    tick(3);
    vectors++;
    if (bus.BOOT_top !== 1'b0) begin miscompares++; $display("FAIL reset_boot_top: got %b expected 0", bus.BOOT_top); end
    vectors++;
    if (bus.SLOT_top !== 4'd0) begin miscompares++; $display("FAIL reset_slot_top: got %0d expected 0", bus.SLOT_top); end
    vectors++;
    if (bus.RESET !== 1'b0) begin miscompares++; $display("FAIL reset_reset: got %b expected 0", bus.RESET); end
    vectors++;
    if (bus.BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
    vectors++;
    if (bus.ERR !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b expected 00", bus.ERR); end
    bus.RESET_top = 1'b0;
    resetn = 1'b1;
    tick(4);
    bus.RESET_top = 1'b1;
    tick(1);
    vectors++;
    if (bus.RESET !== 1'b0) begin miscompares++; $display("FAIL reset_sync_lat1: got %b expected 0", bus.RESET); end
    tick(1);
    vectors++;
    if (bus.RESET !== 1'b1) begin miscompares++; $display("FAIL reset_sync_lat2: got %b expected 1", bus.RESET); end
    bus.RESET_top = 1'b0;
    tick(1);
    vectors++;
    if (bus.RESET !== 1'b1) begin miscompares++; $display("FAIL reset_sync_fall1: got %b expected 1", bus.RESET); end
    tick(1);
    vectors++;
    if (bus.RESET !== 1'b0) begin miscompares++; $display("FAIL reset_sync_fall2: got %b expected 0", bus.RESET); end
    vectors++;
    if (bus.BUSY !== 1'b0 || bus.ERR !== 2'b00) begin
      miscompares++; $display("FAIL reset_idle_status: got busy=%b err=%b expected busy=0 err=00", bus.BUSY, bus.ERR);
    end
  endtask

  task automatic test_valid_request();
    logic       exp_boot;
    logic [3:0] exp_slot;
    bus.BOOT = 1'b1;
    bus.SLOT = 4'd2;
    for (int k = 0; k <= 13; k++) begin
      tick(1);
      if (k == 5) bus.BOOT = 1'b0;
      exp_boot = (k >= 5) && (k <= 12);
      exp_slot = exp_boot ? 4'd2 : 4'd0;
      vectors++;
      if (bus.BOOT_top !== exp_boot || bus.SLOT_top !== exp_slot) begin
        miscompares++;
        $display("FAIL valid_pulse edge %0d: got boot_top=%b slot_top=%0d expected %b/%0d", k, bus.BOOT_top, bus.SLOT_top, exp_boot, exp_slot);
      end
      vectors++;
      if (bus.BUSY !== 1'b1) begin miscompares++; $display("FAIL valid_busy edge %0d: got %b expected 1", k, bus.BUSY); end
    end
    bus.CONFIGURED_top = 1'b0;
    tick(2);
    vectors++;
    if (bus.BUSY !== 1'b1) begin miscompares++; $display("FAIL valid_cfg_lat: got busy=%b expected 1", bus.BUSY); end
    tick(1);
    vectors++;
    if (bus.BUSY !== 1'b0) begin miscompares++; $display("FAIL valid_done_busy: got %b expected 0", bus.BUSY); end
    bus.CONFIGURED_top = 1'b1;
    tick(3);
  endtask

  task automatic test_glitch_filter();
    bus.BOOT = 1'b1;
    bus.SLOT = 4'd2;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (k == 2) bus.BOOT = 1'b0;
      vectors++;
      if (bus.BOOT_top !== 1'b0) begin miscompares++; $display("FAIL glitch_short edge %0d: got %b expected 0", k, bus.BOOT_top); end
    end
    vectors++;
    if (bus.BUSY !== 1'b0) begin miscompares++; $display("FAIL glitch_short_busy: got %b expected 0", bus.BUSY); end
    bus.BOOT = 1'b1;
    bus.SLOT = 4'd2;
    for (int k = 0; k <= 8; k++) begin
      tick(1);
      if (k == 1) bus.SLOT = 4'd1;
      vectors++;
      if (bus.BOOT_top !== (k >= 8)) begin
        miscompares++; $display("FAIL glitch_slot_change edge %0d: got %b expected %b", k, bus.BOOT_top, (k >= 8));
      end
    end
    vectors++;
    if (bus.SLOT_top !== 4'd1) begin miscompares++; $display("FAIL glitch_slot_top: got %0d expected 1", bus.SLOT_top); end
    bus.BOOT = 1'b0;
    tick(8);
    vectors++;
    if (bus.BOOT_top !== 1'b0) begin miscompares++; $display("FAIL glitch_pulse_end: got %b expected 0", bus.BOOT_top); end
    complete_reconf();
  endtask

  task automatic test_bad_slot();
    bus.BOOT = 1'b1;
    bus.SLOT = 4'd5;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      vectors++;
      if (bus.BOOT_top !== 1'b0) begin miscompares++; $display("FAIL bad_slot_boot edge %0d: got %b expected 0", k, bus.BOOT_top); end
      vectors++;
      if (bus.ERR !== ((k >= 4) ? 2'b01 : 2'b00)) begin
        miscompares++; $display("FAIL bad_slot_err edge %0d: got %b expected %b", k, bus.ERR, ((k >= 4) ? 2'b01 : 2'b00));
      end
    end
    vectors++;
    if (bus.BUSY !== 1'b0) begin miscompares++; $display("FAIL bad_slot_busy: got %b expected 0", bus.BUSY); end
    bus.BOOT = 1'b0;
    tick(1);
    bus.BOOT = 1'b1;
    bus.SLOT = 4'd1;
    for (int k = 0; k <= 13; k++) begin
      tick(1);
      if (k == 5) bus.BOOT = 1'b0;
      vectors++;
      if (bus.BOOT_top !== ((k >= 5) && (k <= 12))) begin
        miscompares++; $display("FAIL bad_slot_retry edge %0d: got %b expected %b", k, bus.BOOT_top, ((k >= 5) && (k <= 12)));
      end
    end
    complete_reconf();
    vectors++;
    if (bus.ERR !== 2'b01) begin miscompares++; $display("FAIL bad_slot_sticky: got %b expected 01", bus.ERR); end
  endtask

  task automatic test_timeout();
    bus.BOOT = 1'b1;
    bus.SLOT = 4'd3;
    tick(5);
    vectors++;
    if (bus.BOOT_top !== 1'b0) begin miscompares++; $display("FAIL timeout_pre_pulse: got %b expected 0", bus.BOOT_top); end
    tick(1);
    vectors++;
    if (bus.BOOT_top !== 1'b1 || bus.SLOT_top !== 4'd3) begin
      miscompares++; $display("FAIL timeout_max_slot_pulse: got %b/%0d expected 1/3", bus.BOOT_top, bus.SLOT_top);
    end
    tick(1036 - 5);
    vectors++;
    if (bus.ERR !== 2'b01 || bus.BUSY !== 1'b1) begin
      miscompares++; $display("FAIL timeout_before: got err=%b busy=%b expected 01/1", bus.ERR, bus.BUSY);
    end
    tick(1);
    vectors++;
    if (bus.ERR !== 2'b11 || bus.BUSY !== 1'b0) begin
      miscompares++; $display("FAIL timeout_flag: got err=%b busy=%b expected 11/0", bus.ERR, bus.BUSY);
    end
    for (int k = 0; k < 8; k++) begin
      tick(1);
      vectors++;
      if (bus.BOOT_top !== 1'b0 || bus.BUSY !== 1'b0) begin
        miscompares++; $display("FAIL timeout_no_retrigger cycle %0d: got %b/%b expected 0/0", k, bus.BOOT_top, bus.BUSY);
      end
    end
    bus.BOOT = 1'b0;
    tick(1);
    bus.BOOT = 1'b1;
    bus.SLOT = 4'd0;
    for (int k = 0; k <= 5; k++) begin
      tick(1);
      vectors++;
      if (bus.BOOT_top !== (k >= 5)) begin
        miscompares++; $display("FAIL timeout_back_to_idle edge %0d: got %b expected %b", k, bus.BOOT_top, (k >= 5));
      end
    end
    bus.BOOT = 1'b0;
    tick(10);
    complete_reconf();
  endtask

  task automatic test_reset_mid_pulse();
    bus.BOOT = 1'b1;
    bus.SLOT = 4'd2;
    tick(7);
    vectors++;
    if (bus.BOOT_top !== 1'b1 || bus.ERR !== 2'b11) begin
      miscompares++; $display("FAIL midrst_pre: got boot_top=%b err=%b expected 1/11", bus.BOOT_top, bus.ERR);
    end
    resetn = 1'b0;
    tick(1);
    vectors++;
    if (bus.BOOT_top !== 1'b0 || bus.SLOT_top !== 4'd0) begin
      miscompares++; $display("FAIL midrst_truncate: got %b/%0d expected 0/0", bus.BOOT_top, bus.SLOT_top);
    end
    vectors++;
    if (bus.ERR !== 2'b00 || bus.BUSY !== 1'b0) begin
      miscompares++; $display("FAIL midrst_status: got err=%b busy=%b expected 00/0", bus.ERR, bus.BUSY);
    end
    resetn = 1'b1;
    bus.SLOT = 4'd1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      vectors++;
      if (bus.BOOT_top !== (k >= 9) || bus.BUSY !== (k >= 4)) begin
        miscompares++;
        $display("FAIL midrst_reboot edge %0d: got boot_top=%b busy=%b expected %b/%b", k, bus.BOOT_top, bus.BUSY, (k >= 9), (k >= 4));
      end
    end
    vectors++;
    if (bus.SLOT_top !== 4'd1) begin miscompares++; $display("FAIL midrst_slot_top: got %0d expected 1", bus.SLOT_top); end
    bus.BOOT = 1'b0;
    tick(8);
    vectors++;
    if (bus.BOOT_top !== 1'b0 || bus.ERR !== 2'b00) begin
      miscompares++; $display("FAIL midrst_end: got boot_top=%b err=%b expected 0/00", bus.BOOT_top, bus.ERR);
    end
  endtask

  initial begin
    test_reset();
    test_valid_request();
    test_glitch_filter();
    test_bad_slot();
    test_timeout();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
